// File: rtl/ph_cache_arb.sv
// Read-side arbiter for the pulse-height cache: grants one consumer per frame,
// sweeps every cache word in order and streams the data back with its address.
module ph_cache_arb #(
    parameter int AW        = 8,
    parameter int NUM_WORDS = 256,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ph_cache_valid,
    output logic          ph_cache_enb,
    output logic [AW-1:0] ph_cache_raddr,
    input  logic [15:0]   ph_cache_data,
    input  logic          req_bl,
    input  logic          req_pkt,
    output logic          gnt_bl,
    output logic          gnt_pkt,
    output logic [15:0]   rd_data,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic          rd_last,
    output logic          done,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    typedef enum logic {OWN_BL, OWN_PKT} owner_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);
    localparam logic [1:0]    DRAIN_END = 2'(RD_LAT - 1);

    state_t        state;
    state_t        state_nx;
    owner_t        last_gnt;
    logic          gnt_bl_q;
    logic          gnt_pkt_q;
    logic [AW-1:0] addr_cnt;
    logic [1:0]    drain_cnt;
    logic [15:0]   frame_q;
    logic          start;
    logic          pick_bl;

    logic [RD_LAT-1:0] enb_pipe;
    logic [AW-1:0]     addr_pipe [RD_LAT];
    logic [15:0]       data_hold;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        start    = ph_cache_valid && (req_bl || req_pkt);
        pick_bl  = req_bl && (!req_pkt || (last_gnt == OWN_PKT));
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SWEEP;
            SWEEP:   if (addr_cnt == LAST_ADDR) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_END) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt  <= OWN_PKT;
            gnt_bl_q  <= 1'b0;
            gnt_pkt_q <= 1'b0;
            addr_cnt  <= '0;
            drain_cnt <= '0;
            frame_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gnt_bl_q  <= pick_bl;
                        gnt_pkt_q <= !pick_bl;
                    end
                    addr_cnt  <= '0;
                    drain_cnt <= '0;
                end
                SWEEP: begin
                    addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + AW'(1);
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                end
                DONE: begin
                    frame_q   <= frame_q + 16'd1;
                    last_gnt  <= gnt_bl_q ? OWN_BL : OWN_PKT;
                    gnt_bl_q  <= 1'b0;
                    gnt_pkt_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ph_cache_enb   = (state == SWEEP);
    assign ph_cache_raddr = ph_cache_enb ? addr_cnt : '0;
    assign gnt_bl         = gnt_bl_q;
    assign gnt_pkt        = gnt_pkt_q;
    assign done           = (state == DONE);
    assign busy           = (state != IDLE);
    assign frame_cnt      = frame_q;

    // NOTE: the delay lines are reset (unlike a data RAM) because a reset
    // mid-sweep must flush in-flight reads so no stale rd_valid escapes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enb_pipe  <= '0;
            data_hold <= '0;
            for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
        end else begin
            enb_pipe[0]  <= ph_cache_enb;
            addr_pipe[0] <= ph_cache_raddr;
            for (int i = 1; i < RD_LAT; i++) begin
                enb_pipe[i]  <= enb_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            if (rd_valid) data_hold <= ph_cache_data;
        end
    end

    // Cache data is live only while rd_valid; otherwise replay the last word.
    assign rd_valid = enb_pipe[RD_LAT-1];
    assign rd_addr  = addr_pipe[RD_LAT-1];
    assign rd_last  = rd_valid && (rd_addr == LAST_ADDR);
    assign rd_data  = rd_valid ? ph_cache_data : data_hold;

endmodule

// File: doc/ph_cache_arb.md
Name: ph_cache_arb

Overview:
- Read-side controller for the pulse-height cache.
- Shares the cache read port (enb/raddr/data) between two consumers: the baseline engine (BL) and the event packetizer (PKT).
- Waits for a complete frame (ph_cache_valid), grants one requester, sweeps all cache addresses in order, and streams the data to that requester.
- The final address of the sweep (NUM_WORDS-1) is what clears ph_cache_valid inside the cache, so each frame is consumed by exactly one requester.

Parameters:
- AW, 8, cache read address width.
- NUM_WORDS, 256, words swept per frame; last swept address = NUM_WORDS-1.
- RD_LAT, 1, cache read latency in cycles from enb/raddr to valid data; legal range 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ph_cache_valid  in  1  cache holds a complete frame
- ph_cache_enb  out  1  cache read enable
- ph_cache_raddr  out  AW  cache read address
- ph_cache_data  in  16  cache read data
- req_bl  in  1  BL requests the next frame (level)
- req_pkt  in  1  PKT requests the next frame (level)
- gnt_bl  out  1  BL owns the current sweep
- gnt_pkt  out  1  PKT owns the current sweep
- rd_data  out  16  streamed cache word
- rd_addr  out  AW  address of rd_data
- rd_valid  out  1  rd_data/rd_addr qualifier
- rd_last  out  1  with rd_valid, marks the word at address NUM_WORDS-1
- done  out  1  one-cycle pulse after the last word of a sweep
- busy  out  1  high in any state other than IDLE
- frame_cnt  out  16  completed sweeps; wraps 0xFFFF->0

Behaviour:
Reset (rst_n=0 at a clk edge):
- All outputs go to 0; state=IDLE; last_gnt=PKT, so BL wins the first tie.
- Reset mid-sweep aborts the sweep and flushes the read pipeline; no rd_valid and no done follow.

Address rules:
- ph_cache_raddr is 0 in every state except SWEEP.
- Address NUM_WORDS-1 is driven for exactly one cycle per sweep, and only with enb=1.

FSM (IDLE, SWEEP, DRAIN, DONE):
- IDLE:
  - When ph_cache_valid=1 and (req_bl|req_pkt): grant on the next edge and enter SWEEP.
  - If one requester is active, it wins. If both are active, the one that is not last_gnt wins (round robin).
  - Requests are sampled only in IDLE; changes during SWEEP/DRAIN/DONE are ignored.
  - If ph_cache_valid=1 with no request, stay in IDLE and do not touch the cache.
- SWEEP:
  - gnt_x=1, enb=1.
  - raddr starts at 0 on the first SWEEP cycle and increments by 1 each cycle.
  - After the cycle with raddr=NUM_WORDS-1, go to DRAIN.
  - Duration is exactly NUM_WORDS cycles; there is no stall.
- DRAIN:
  - enb=0, raddr=0, gnt held.
  - Stay RD_LAT cycles, then go to DONE.
- DONE:
  - One cycle: done=1, frame_cnt+1, last_gnt<=current grant.
  - Grant drops on the exit edge; return to IDLE.

Read pipeline:
- enb and raddr are each delayed by RD_LAT registers to produce rd_valid and rd_addr.
- rd_data = ph_cache_data sampled with rd_valid.
- First rd_valid appears RD_LAT cycles after the first enb.
- NUM_WORDS consecutive rd_valid cycles; rd_last coincides with rd_addr=NUM_WORDS-1.
- The last rd_valid occurs in the final DRAIN cycle.
- rd_data holds its last value when rd_valid=0.

Grants:
- gnt_bl and gnt_pkt are never both 1.
- The grant is stable from the first SWEEP cycle through DONE inclusive.

Back-to-back frames:
- ph_cache_valid is still 1 in the cycle after DONE only if the cache has already re-armed. In that case a new grant is issued from IDLE, with one IDLE cycle minimum between sweeps.

Test Plan:
- Reset → req_bl=1, ph_cache_valid=1 → gnt_bl at cycle 1; raddr 0..255 over 256 cycles; with RD_LAT=1, rd_valid cycles 2..257, rd_last with rd_addr=255, done pulse one cycle later; frame_cnt=1.
- req_bl=req_pkt=1 held, three frames → grants BL, PKT, BL; never both high; frame_cnt=3.
- ph_cache_valid=1, no requests for 100 cycles → enb stays 0, raddr=0, busy=0; req_pkt rises → sweep starts next cycle with gnt_pkt=1.
- req_bl dropped at sweep word 10 → sweep still completes all 256 words, done=1, gnt_bl held until DONE.
- rst_n=0 at raddr=100 for 1 cycle → next cycle all outputs 0; no rd_valid or done afterward; a new sweep starts at raddr=0 once requested.
- RD_LAT=3 with cache model data=addr → rd_data equals rd_addr for all 256 words; DRAIN lasts 3 cycles.
